// File: rtl/fp_issue_ctrl.sv
// Issue/handshake stage between the EX stage and the FP execute core: one op in flight,
// start pulse, result capture, writeback hold and sticky fflags. Optional macro: FP_TIMEOUT_EN.
module fp_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic        fp_start,
    output logic [2:0]  fp_op,
    output logic [31:0] fp_a,
    output logic [31:0] fp_b,
    input  logic [31:0] fp_result,
    input  logic [4:0]  fp_flags,
    input  logic        fp_valid,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_flags,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  flags_q, flags_d;
    logic [4:0]  fflags_q, fflags_d;
    logic        capture;
    logic [31:0] cap_data;
    logic [4:0]  cap_flags;

`ifdef FP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        data_d    = data_q;
        flags_d   = flags_q;
        fflags_d  = fflags_q;
        capture   = 1'b0;
        cap_data  = fp_result;
        cap_flags = fp_flags;
`ifdef FP_TIMEOUT_EN
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    rd_d    = req_rd;
                    state_d = ISSUE;
`ifdef FP_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                // The core may answer special cases in the same cycle as start.
                if (fp_valid) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
`ifdef FP_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (fp_valid) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
`ifdef FP_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    // Forced completion returns a quiet NaN flagged invalid.
                    if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                        capture   = 1'b1;
                        cap_data  = 32'h7FC0_0000;
                        cap_flags = 5'b10000;
                        tmo_d     = 1'b1;
                        state_d   = RESP;
                    end
                end
`endif
            end
            RESP: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            data_d   = cap_data;
            flags_d  = cap_flags;
            fflags_d = (fflags_clr ? 5'b0 : fflags_q) | cap_flags;
        end else if (fflags_clr) begin
            fflags_d = 5'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            flags_q  <= '0;
            fflags_q <= '0;
`ifdef FP_TIMEOUT_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
            fflags_q <= fflags_d;
`ifdef FP_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign fp_start  = (state_q == ISSUE);
    assign wb_valid  = (state_q == RESP);
    assign fp_op     = op_q;
    assign fp_a      = a_q;
    assign fp_b      = b_q;
    assign wb_rd     = rd_q;
    assign wb_data   = data_q;
    assign wb_flags  = flags_q;
    assign fflags    = fflags_q;
`ifdef FP_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
